// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential MIPS HI/LO multiply/divide unit.
package muldiv_pkg;

    // Operation codes as they arrive on the op port.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    // Sequencer states: capture, magnitude prep, iterate, sign fix.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        RUN  = 2'b10,
        FIX  = 2'b11
    } md_state_t;

    // ALU function codes used by the sequencer.
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // True for the two's-complement variants (MULT, DIV).
    function automatic logic isSignedOp(input md_op_t o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

    // True for the divide variants (DIV, DIVU).
    function automatic logic isDivOp(input md_op_t o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_seq_alu.sv
// Small MIPS-style ALU: AND, OR, ADD, SUB, SLT with carry-out and zero flag.
// cout is the carry of a + (b or ~b) + f[2], so for SUB cout=1 means no borrow.
module alu_32bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       f_i,
    output logic [WIDTH-1:0] y_o,
    output logic             cout_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] bEff;
    logic [WIDTH:0]   sum;
    logic             ovf;

    // Shared adder with optional inversion of b; f[1:0] selects the result.
    always_comb begin
        bEff   = f_i[2] ? ~b_i : b_i;
        sum    = {1'b0, a_i} + {1'b0, bEff} + {{WIDTH{1'b0}}, f_i[2]};
        ovf    = (a_i[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
        cout_o = sum[WIDTH];
        case (f_i[1:0])
            2'b00:   y_o = a_i & bEff;
            2'b01:   y_o = a_i | bEff;
            2'b10:   y_o = sum[WIDTH-1:0];
            default: y_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
        endcase
        zero_o = (y_o == '0);
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU).
// One shared ALU performs the shift-add multiply and restoring-divide steps;
// signed operations run on magnitudes and are sign-corrected at the end.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_t        state_q;
    md_op_t           op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] low_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CW-1:0]    cnt_q;
    logic             negQuot_q, negRem_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             isDiv, isSigned, divZero;
    logic [WIDTH-1:0] aMag, bMag;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   mulSum;
    logic             qBit;
    logic [WIDTH-1:0] aluA, aluY;
    logic [2:0]       aluF;
    logic             aluCout, aluZeroUnused;
    logic [WIDTH-1:0] accStep_d, lowStep_d;
    logic [2*WIDTH-1:0] prodNeg;
    logic [WIDTH-1:0] fixHi_d, fixLo_d;

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Operation decode, operand magnitudes, and the ALU operand/function select.
    always_comb begin
        isDiv    = isDivOp(op_q);
        isSigned = isSignedOp(op_q);
        divZero  = isDiv && (b_q == '0);
        aMag     = (isSigned && a_q[WIDTH-1]) ? -a_q : a_q;
        bMag     = (isSigned && b_q[WIDTH-1]) ? -b_q : b_q;
        remShift = {acc_q, low_q[WIDTH-1]};
        aluA     = isDiv ? remShift[WIDTH-1:0] : acc_q;
        aluF     = (state_q == RUN && isDiv) ? ALU_SUB : ALU_ADD;
    end

    alu_32bit #(.WIDTH(WIDTH)) uAlu (
        .a_i    (aluA),
        .b_i    (opnd_q),
        .f_i    (aluF),
        .y_o    (aluY),
        .cout_o (aluCout),
        .zero_o (aluZeroUnused)
    );

    // One iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
    always_comb begin
        mulSum = low_q[0] ? {aluCout, aluY} : {1'b0, acc_q};
        qBit   = remShift[WIDTH] | aluCout;
        if (isDiv) begin
            accStep_d = qBit ? aluY : remShift[WIDTH-1:0];
            lowStep_d = {low_q[WIDTH-2:0], qBit};
        end else begin
            accStep_d = mulSum[WIDTH:1];
            lowStep_d = {mulSum[0], low_q[WIDTH-1:1]};
        end
    end

    // Final HI/LO values: sign correction, or the fixed divide-by-zero pattern.
    always_comb begin
        prodNeg = -{acc_q, low_q};
        fixHi_d = acc_q;
        fixLo_d = low_q;
        if (divZero) begin
            fixHi_d = a_q;
            fixLo_d = '1;
        end else if (!isDiv) begin
            if (negQuot_q) begin
                fixHi_d = prodNeg[2*WIDTH-1:WIDTH];
                fixLo_d = prodNeg[WIDTH-1:0];
            end
        end else begin
            if (negQuot_q) fixLo_d = -low_q;
            if (negRem_q)  fixHi_d = -acc_q;
        end
    end

    // Sequencer with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= MD_MULT;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            low_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= md_op_t'(op);
                        a_q     <= a;
                        b_q     <= b;
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    low_q     <= isDiv ? aMag : bMag;
                    opnd_q    <= isDiv ? bMag : aMag;
                    negQuot_q <= isSigned && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    negRem_q  <= isSigned && a_q[WIDTH-1];
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    busy_q    <= 1'b1;
                    state_q   <= RUN;
                end
                RUN: begin
                    acc_q <= accStep_d;
                    low_q <= lowStep_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= fixHi_d;
                    lo_q    <= fixLo_d;
                    done_q  <= 1'b1;
                    dbz_q   <= divZero;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases, protocol cases and
// randomized operations compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, divByZero;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (divByZero),
        .hi          (hi),
        .lo          (lo)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Architectural result of one operation, straight from the MIPS definition.
    function automatic void refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] expHi, output logic [31:0] expLo,
                                     output logic expDbz);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        expDbz = 1'b0;
        p = '0;
        q = 0;
        r = 0;
        case (o)
            OP_MULT:  p = 64'(sx * sy);
            OP_MULTU: p = {32'd0, x} * {32'd0, y};
            OP_DIV: begin
                if (y == 0) begin
                    p = {x, 32'hFFFF_FFFF};
                    expDbz = 1'b1;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) begin
                    p = {x, 32'hFFFF_FFFF};
                    expDbz = 1'b1;
                end else begin
                    p = {x % y, x / y};
                end
            end
        endcase
        expHi = p[63:32];
        expLo = p[31:0];
    endfunction

    // One comparison; a miscompare is counted and reported.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            $error("[TB] miscompare in %s", tag);
        end
    endtask

    // Present a one-cycle start pulse; returns just after the sampling edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting cycles and busy samples on the way.
    task automatic waitForDone(output int lat, output int busyCnt);
        lat = 0;
        busyCnt = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busyCnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("doneSeen", 32'(done), 32'd1);
    endtask

    // Full operation with result, flag and timing checks.
    task automatic doOperation(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat, busyCnt;
        logic [31:0] eh, el;
        logic ed;
        applyStimulus(o, x, y);
        waitForDone(lat, busyCnt);
        refModel(o, x, y, eh, el, ed);
        checkOutput({tag, ".hi"}, hi, eh);
        checkOutput({tag, ".lo"}, lo, el);
        checkOutput({tag, ".dbz"}, 32'(divByZero), 32'(ed));
        checkOutput({tag, ".latency"}, 32'(lat), 32'd34);
        checkOutput({tag, ".busyCycles"}, 32'(busyCnt), 32'd33);
        checkOutput({tag, ".busyAtDone"}, 32'(busy), 32'd0);
    endtask

    // Directed sequence followed by randomized operations.
    initial begin
        int lat, busyCnt;
        logic [31:0] eh, el, holdHi, holdLo, x, y;
        logic ed;
        logic [1:0] o;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.dbz", 32'(divByZero), 32'd0);
        checkOutput("reset.hi", hi, 32'd0);
        checkOutput("reset.lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        doOperation("multu7x6", OP_MULTU, 32'd7, 32'd6);
        checkOutput("multu7x6.loConst", lo, 32'd42);
        holdHi = hi;
        holdLo = lo;
        @(posedge clk);
        #1;
        checkOutput("donePulse", 32'(done), 32'd0);
        checkOutput("holdHi", hi, holdHi);
        checkOutput("holdLo", lo, holdLo);

        doOperation("multNeg", OP_MULT, 32'hFFFF_FFFD, 32'd5);
        checkOutput("multNeg.hiConst", hi, 32'hFFFF_FFFF);
        checkOutput("multNeg.loConst", lo, 32'hFFFF_FFF1);
        doOperation("multuMax", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multuMax.hiConst", hi, 32'hFFFF_FFFE);
        doOperation("divu100by7", OP_DIVU, 32'd100, 32'd7);
        checkOutput("divu100by7.loConst", lo, 32'd14);
        doOperation("divNeg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput("divNeg7by2.hiConst", hi, 32'hFFFF_FFFF);
        doOperation("div5by0", OP_DIV, 32'd5, 32'd0);
        checkOutput("div5by0.hiConst", hi, 32'd5);
        doOperation("divNegBy0", OP_DIV, 32'hFFFF_FF00, 32'd0);
        doOperation("divuBy0", OP_DIVU, 32'h8000_0001, 32'd0);
        doOperation("divOverflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("divOverflow.loConst", lo, 32'h8000_0000);
        doOperation("divNegDivisor", OP_DIV, 32'd17, 32'hFFFF_FFFB);
        doOperation("multBothNeg", OP_MULT, 32'h8000_0000, 32'h8000_0000);

        applyStimulus(OP_DIV, 32'hFFFF_FC18, 32'd33);
        repeat (6) @(posedge clk);
        @(negedge clk);
        op = OP_MULTU;
        a = 32'd5;
        b = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitForDone(lat, busyCnt);
        refModel(OP_DIV, 32'hFFFF_FC18, 32'd33, eh, el, ed);
        checkOutput("ignoreStart.hi", hi, eh);
        checkOutput("ignoreStart.lo", lo, el);
        @(posedge clk);
        #1;
        checkOutput("ignoreStart.noQueueDone", 32'(done), 32'd0);
        checkOutput("ignoreStart.noQueueBusy", 32'(busy), 32'd0);

        applyStimulus(OP_MULTU, 32'hDEAD_BEEF, 32'h0001_2345);
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midReset.busy", 32'(busy), 32'd0);
        checkOutput("midReset.done", 32'(done), 32'd0);
        checkOutput("midReset.hi", hi, 32'd0);
        checkOutput("midReset.lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        doOperation("afterReset", OP_DIVU, 32'd1000, 32'd10);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) y = 32'd0;
            else if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(16, 30);
            doOperation($sformatf("rand%0d", i), o, x, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
